serial_add_ctrl: RTL and testbench

Multi-cycle sequencer that adds two WIDTH-bit operands by reusing one 2-bit adder slice over WIDTH/2 consecutive cycles, LSB pair first. The block latches the operands and steps the slice through them. It carries the slice carry-out between steps and assembles the result. It sits between a requester (start/done handshake) and the 2-bit adder datapath, so wide additions cost no extra adder area.

---
 rtl/serial_add_ctrl_pkg.sv | 14 +
 rtl/serial_add_ctrl_add_slice.sv | 22 ++
 rtl/serial_add_ctrl.sv | 119 +++++++++++
 tb/tb_serial_add_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the serial adder sequencer: state encoding and slice width.
package serial_add_ctrl_pkg;

    // Width of the reused adder slice; each RUN step consumes this many operand bits.
    localparam int SLICE_W = 2;

    // 2'd3 is unused and steers back to IDLE through the next-state default.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_add_slice.sv
// Combinational 2-bit ripple-carry adder slice, reused every step by the sequencer.
module add_slice
    import serial_add_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic c_mid;

    // Two full-adder cells, carry rippling from bit 0 into bit 1.
    always_comb begin
        s[0]  = a[0] ^ b[0] ^ ci;
        c_mid = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
        s[1]  = a[1] ^ b[1] ^ c_mid;
        co    = (a[1] & b[1]) | (c_mid & (a[1] ^ b[1]));
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Serial adder sequencer: adds two WIDTH-bit operands two bits per cycle
// through a single add_slice, LSB pair first.
//
//   state | meaning
//   IDLE  | waiting for start; sum/co hold the last result
//   RUN   | one slice step per cycle, N = WIDTH/2 steps
//   DONE  | one-cycle done pulse, result valid, back to IDLE
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;
    logic               last_step;

    add_slice u_slice (
        .a  (a_sh[SLICE_W-1:0]),
        .b  (b_sh[SLICE_W-1:0]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    assign last_step = (cnt == LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nxt = IDLE;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = start ? RUN : IDLE;
            end
            RUN: begin
                busy      = 1'b1;
                state_nxt = last_step ? DONE : RUN;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, per-step shifting, carry chaining and result assembly.
    // The counter stops at LAST rather than wrapping, since RUN exits there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            co    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= ci;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum   <= {slice_s, sum[WIDTH-1:SLICE_W]};
                    carry <= slice_co;
                    a_sh  <= a_sh >> SLICE_W;
                    b_sh  <= b_sh >> SLICE_W;
                    if (last_step) begin
                        co <= slice_co;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl against plain a+b+ci arithmetic.
module tb_serial_add_ctrl;

    localparam int W = 8;
    localparam int N = W / 2;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         co;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic civ);
        return {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, civ};
    endfunction

    // Wait for done after an accept edge; returns the number of edges taken.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // One full operation with a random idle gap afterwards checking result stability.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ,
                         input int gap);
        logic [W:0] exp;
        int n;
        exp = model(av, bv, civ);
        @(negedge clk);
        a = av; b = bv; ci = civ; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        wait_done(n);
        chk("latency", 32'(n), 32'(N));
        chk("sum", 32'(sum), 32'(exp[W-1:0]));
        chk("co", 32'(co), 32'(exp[W]));
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_back_idle", 32'(busy), 32'd0);
        for (int g = 0; g < gap; g++) begin
            a = W'($urandom); b = W'($urandom);
            @(posedge clk);
            #1;
            chk("sum_stable", 32'(sum), 32'(exp[W-1:0]));
            chk("co_stable", 32'(co), 32'(exp[W]));
        end
    endtask

    initial begin
        logic [W-1:0] a1, b1, a3, b3;
        logic         c1;
        logic [W:0]   e;
        int           n;
        int           seen;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases.
        do_op(8'h00, 8'h00, 1'b0, 1);
        do_op(8'h12, 8'h34, 1'b0, 2);
        do_op(8'hFF, 8'h01, 1'b0, 0);
        do_op(8'hAA, 8'h55, 1'b1, 1);
        do_op(8'hFF, 8'hFF, 1'b1, 3);

        // start held high throughout, operands changing every cycle.
        a1 = 8'h5C; b1 = 8'hB7; c1 = 1'b1;
        @(negedge clk);
        a = a1; b = b1; ci = c1; start = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        e = model(a1, b1, c1);
        chk("hold_latency", 32'(n), 32'(N));
        chk("hold_sum", 32'(sum), 32'(e[W-1:0]));
        chk("hold_co", 32'(co), 32'(e[W]));
        @(negedge clk);
        a = W'($urandom); b = W'($urandom);
        @(posedge clk);
        #1;
        chk("hold_idle_busy", 32'(busy), 32'd0);
        a3 = 8'h9E; b3 = 8'h73;
        @(negedge clk);
        a = a3; b = b3; ci = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(n);
        e = model(a3, b3, 1'b0);
        chk("b2b_latency", 32'(n), 32'(N));
        chk("b2b_sum", 32'(sum), 32'(e[W-1:0]));
        chk("b2b_co", 32'(co), 32'(e[W]));
        @(posedge clk);
        #1;

        // Asynchronous reset in the second RUN cycle.
        @(negedge clk);
        a = 8'hF3; b = 8'h2D; ci = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_co", 32'(co), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("arst_no_done", 32'(seen), 32'd0);
        do_op(8'h3C, 8'hC4, 1'b0, 1);

        // Random sweep.
        for (int k = 0; k < 1000; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
